// File: rtl/wb_burst_ram.sv
// Wishbone B4 slave RAM with registered read data, byte-lane writes and CTI/BTE bursts.
// Word addresses at or beyond DEPTH terminate with err_o instead of ack_o.
module wb_burst_ram #(
   parameter int         DAT_WIDTH = 32,
   parameter int         ADR_WIDTH = 13,
   parameter int         SEL_WIDTH = 4,
   parameter int         GRN_WIDTH = 8,
   parameter int         DEPTH     = 2048,
   parameter logic [1:0] TGD       = 2'h0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cyc_i,
   input  logic                 stb_i,
   input  logic                 we_i,
   input  logic [ADR_WIDTH-1:0] adr_i,
   input  logic [SEL_WIDTH-1:0] sel_i,
   input  logic [DAT_WIDTH-1:0] dat_i,
   input  logic [2:0]           cti_i,
   input  logic [1:0]           bte_i,
   output logic [DAT_WIDTH-1:0] dat_o,
   output logic                 ack_o,
   output logic                 err_o,
   output logic                 rty_o,
   output logic [1:0]           tgd_o
);

   localparam int LSB  = $clog2(SEL_WIDTH);
   localparam int WA_W = ADR_WIDTH - LSB;
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [WA_W:0] DEPTH_W = (WA_W+1)'(DEPTH);

   localparam logic [2:0] CTI_INCR = 3'b010;
   localparam logic [2:0] CTI_END  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SINGLE = 2'd1,
      S_BURST  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 ack_q, ack_d;
   logic                 err_q, err_d;
   logic [DAT_WIDTH-1:0] dat_q;
   logic [WA_W-1:0]      bcnt_q, bcnt_d;
   logic [1:0]           bte_q, bte_d;

   logic                 req;
   logic [WA_W-1:0]      wa;
   logic                 wa_ok;
   logic [WA_W:0]        na;
   logic                 na_ok;
   logic                 rd_en;
   logic [WA_W-1:0]      rd_wa;
   logic                 wr_en;

   logic [DAT_WIDTH-1:0] mem_q [DEPTH];

   // Handshake: a beat completes in any cycle with cyc_i & stb_i & ack_o; ack_o/err_o are
   // registered from the previous cycle's request, and the master holds a beat until it completes.
   assign req   = cyc_i & stb_i;
   assign wa    = adr_i[ADR_WIDTH-1:LSB];
   assign wa_ok = {1'b0, wa} < DEPTH_W;

   wire unused_adr_lsb = ^adr_i[LSB-1:0];

   // Next burst word: linear increments, wrap modes roll only the low 2/3/4 bits.
   always_comb begin
      na = {1'b0, bcnt_q} + (WA_W+1)'(1);
      case (bte_q)
         2'b01:   na = {1'b0, bcnt_q[WA_W-1:2], bcnt_q[1:0] + 2'd1};
         2'b10:   na = {1'b0, bcnt_q[WA_W-1:3], bcnt_q[2:0] + 3'd1};
         2'b11:   na = {1'b0, bcnt_q[WA_W-1:4], bcnt_q[3:0] + 4'd1};
         default: na = {1'b0, bcnt_q} + (WA_W+1)'(1);
      endcase
   end

   assign na_ok = na < DEPTH_W;

   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      bcnt_d  = bcnt_q;
      bte_d   = bte_q;
      rd_en   = 1'b0;
      rd_wa   = bcnt_q;
      wr_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // The cycle carrying err_o still shows the failed request; it must not restart.
            if (req && !err_q) begin
               if (!wa_ok) begin
                  err_d = 1'b1;
               end else begin
                  ack_d   = 1'b1;
                  bcnt_d  = wa;
                  bte_d   = bte_i;
                  rd_en   = 1'b1;
                  rd_wa   = wa;
                  state_d = (cti_i == CTI_INCR) ? S_BURST : S_SINGLE;
               end
            end
         end
         S_SINGLE: begin
            wr_en   = req & ack_q & we_i;
            state_d = S_IDLE;
         end
         S_BURST: begin
            if (!cyc_i) begin
               state_d = S_IDLE;
            end else if (req && ack_q) begin
               wr_en = we_i;
               if (cti_i == CTI_END) begin
                  state_d = S_IDLE;
               end else if (!na_ok) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ack_d  = 1'b1;
                  bcnt_d = na[WA_W-1:0];
                  rd_en  = 1'b1;
                  rd_wa  = na[WA_W-1:0];
               end
            end else begin
               // Wait state or resume: re-read the held beat so dat_o is current on the next ack.
               ack_d = req;
               rd_en = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         bcnt_q  <= '0;
         bte_q   <= 2'b00;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         bcnt_q  <= bcnt_d;
         bte_q   <= bte_d;
         if (rd_en) begin
            dat_q <= mem_q[rd_wa[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en && wa_ok && !rst_i) begin
         for (int i = 0; i < SEL_WIDTH; i++) begin
            if (sel_i[i]) begin
               mem_q[wa[AW-1:0]][i*GRN_WIDTH +: GRN_WIDTH] <= dat_i[i*GRN_WIDTH +: GRN_WIDTH];
            end
         end
      end
   end

   assign dat_o = dat_q;
   assign ack_o = ack_q;
   assign err_o = err_q;
   assign rty_o = 1'b0;
   assign tgd_o = TGD;

endmodule
